// File: rtl/cache_line_wb.sv
// Single write-back cache line with per-word dirty tracking, TTL and
// ready/valid memory handshake for the hybrid cache.
module cache_line_wb #(
  parameter int ADDRBITS = 32,
  parameter int DATABITS = 32,
  parameter int LSBBITS  = 7,
  parameter int TTLBITS  = 8,
  parameter int MAXTTL   = 2**TTLBITS-1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [ADDRBITS-1:0]         dcache_line_rdaddr,
  input  logic                        dcache_line_rdreq,
  output logic [DATABITS-1:0]         dcache_line_out,
  output logic                        dcache_line_out_valid,
  input  logic [ADDRBITS-1:0]         dcache_line_wraddr,
  input  logic [DATABITS-1:0]         dcache_line_in,
  input  logic [DATABITS/8-1:0]       dcache_line_in_be,
  input  logic                        dcache_line_wrreq,
  input  logic [ADDRBITS-1:0]         icache_line_rdaddr,
  input  logic                        icache_line_rdreq,
  output logic [DATABITS-1:0]         icache_line_out,
  output logic                        icache_line_out_valid,
  output logic                        cache_line_miss,
  output logic                        cache_line_dirty,
  output logic                        cache_line_empty,
  output logic [TTLBITS-1:0]          cache_line_ttl,
  output logic                        cache_line_ready,
  input  logic                        cache_line_flush,
  input  logic                        cache_line_fill,
  input  logic [ADDRBITS-LSBBITS-1:0] cache_new_region,
  output logic [ADDRBITS-1:0]         mem_addr,
  output logic [DATABITS-1:0]         mem_out,
  output logic                        mem_wrreq,
  output logic                        mem_rdreq,
  input  logic                        mem_ready,
  input  logic [DATABITS-1:0]         mem_in,
  input  logic                        mem_in_valid
);

  localparam int BB    = DATABITS/8;
  localparam int OFFB  = $clog2(BB);
  localparam int IDXB  = LSBBITS-OFFB;
  localparam int WORDS = 2**IDXB;
  localparam int TAGB  = ADDRBITS-LSBBITS;
  localparam logic [TTLBITS-1:0] TTLMAX = TTLBITS'(MAXTTL);

  localparam logic [1:0] S_CACHING  = 2'd0;
  localparam logic [1:0] S_FLUSHING = 2'd1;
  localparam logic [1:0] S_FILLING  = 2'd2;

  logic [1:0]          r_state;
  logic [DATABITS-1:0] r_mem [WORDS];
  logic [WORDS-1:0]    r_dirty;
  logic [TAGB-1:0]     r_tag;
  logic [TAGB-1:0]     r_new_tag;
  logic                r_fill_pend;
  logic                r_empty;
  logic [TTLBITS-1:0]  r_ttl;
  logic [IDXB-1:0]     r_idx;
  logic [IDXB-1:0]     r_rcv;
  logic [DATABITS-1:0] r_dout;
  logic                r_dvalid;
  logic [DATABITS-1:0] r_iout;
  logic                r_ivalid;
  logic [ADDRBITS-1:0] r_mem_addr;
  logic [DATABITS-1:0] r_mem_out;
  logic                r_wrreq;
  logic                r_rdreq;

  logic            w_caching;
  logic            w_live;
  logic            w_dhit;
  logic            w_ihit;
  logic            w_whit;
  logic [IDXB-1:0] w_didx;
  logic [IDXB-1:0] w_iidx;
  logic [IDXB-1:0] w_widx;
  logic [IDXB-1:0] w_idx_inc;
  logic            w_last;
  logic            w_dirty_nxt;
  logic            w_step;
  logic            w_unused;

  assign w_caching = (r_state == S_CACHING);
  assign w_live    = w_caching && !r_empty;
  assign w_dhit    = w_live && dcache_line_rdreq &&
                     (dcache_line_rdaddr[ADDRBITS-1:LSBBITS] == r_tag);
  assign w_ihit    = w_live && icache_line_rdreq &&
                     (icache_line_rdaddr[ADDRBITS-1:LSBBITS] == r_tag);
  assign w_whit    = w_live && dcache_line_wrreq &&
                     (dcache_line_wraddr[ADDRBITS-1:LSBBITS] == r_tag);
  assign w_didx    = dcache_line_rdaddr[LSBBITS-1:OFFB];
  assign w_iidx    = icache_line_rdaddr[LSBBITS-1:OFFB];
  assign w_widx    = dcache_line_wraddr[LSBBITS-1:OFFB];
  assign w_idx_inc = r_idx + 1'b1;
  assign w_last    = &r_idx;
  assign w_dirty_nxt = (|r_dirty) || w_whit;
  // Flush scan advances on an accepted write or past a clean word
  assign w_step    = r_wrreq ? mem_ready : !r_dirty[r_idx];
  assign w_unused  = ^{dcache_line_rdaddr[OFFB-1:0],
                       dcache_line_wraddr[OFFB-1:0],
                       icache_line_rdaddr[OFFB-1:0]};

  assign cache_line_miss = w_caching && !(w_dhit || w_ihit || w_whit) &&
                           (dcache_line_rdreq || icache_line_rdreq ||
                            dcache_line_wrreq);
  assign cache_line_dirty      = |r_dirty;
  assign cache_line_empty      = r_empty;
  assign cache_line_ttl        = r_ttl;
  assign cache_line_ready      = w_caching;
  assign dcache_line_out       = r_dout;
  assign dcache_line_out_valid = r_dvalid;
  assign icache_line_out       = r_iout;
  assign icache_line_out_valid = r_ivalid;
  assign mem_addr              = r_mem_addr;
  assign mem_out               = r_mem_out;
  assign mem_wrreq             = r_wrreq;
  assign mem_rdreq             = r_rdreq;

  always_ff @(posedge clk) begin
    if (w_whit) begin
      for (int b = 0; b < BB; b++) begin
        if (dcache_line_in_be[b])
          r_mem[w_widx][8*b +: 8] <= dcache_line_in[8*b +: 8];
      end
    end
    if (r_state == S_FILLING && mem_in_valid)
      r_mem[r_rcv] <= mem_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_CACHING;
      r_dirty     <= '0;
      r_tag       <= '0;
      r_new_tag   <= '0;
      r_fill_pend <= 1'b0;
      r_empty     <= 1'b1;
      r_ttl       <= '0;
      r_idx       <= '0;
      r_rcv       <= '0;
      r_dout      <= '0;
      r_dvalid    <= 1'b0;
      r_iout      <= '0;
      r_ivalid    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_out   <= '0;
      r_wrreq     <= 1'b0;
      r_rdreq     <= 1'b0;
    end else begin
      r_dvalid <= w_dhit;
      r_ivalid <= w_ihit;
      if (w_dhit) r_dout <= r_mem[w_didx];
      if (w_ihit) r_iout <= r_mem[w_iidx];
      unique case (1'b1)
        (r_state == S_CACHING): begin
          if (w_whit) r_dirty[w_widx] <= 1'b1;
          if (cache_line_fill) begin
            r_new_tag   <= cache_new_region;
            r_fill_pend <= 1'b1;
            r_idx       <= '0;
            r_ttl       <= '0;
            if (w_dirty_nxt) begin
              r_state <= S_FLUSHING;
            end else begin
              r_state    <= S_FILLING;
              r_rdreq    <= 1'b1;
              r_rcv      <= '0;
              r_mem_addr <= {cache_new_region, {LSBBITS{1'b0}}};
            end
          end else if (cache_line_flush) begin
            r_fill_pend <= 1'b0;
            r_idx       <= '0;
            r_ttl       <= '0;
            if (w_dirty_nxt) r_state <= S_FLUSHING;
            else             r_empty <= 1'b1;
          end else if (r_empty) begin
            r_ttl <= '0;
          end else if (w_dhit || w_ihit || w_whit) begin
            r_ttl <= TTLMAX;
          end else if (r_ttl != '0) begin
            r_ttl <= r_ttl - 1'b1;
          end
        end
        (r_state == S_FLUSHING): begin
          if (r_wrreq && mem_ready) begin
            r_wrreq        <= 1'b0;
            r_dirty[r_idx] <= 1'b0;
          end else if (!r_wrreq && r_dirty[r_idx]) begin
            r_wrreq    <= 1'b1;
            r_mem_addr <= {r_tag, r_idx, {OFFB{1'b0}}};
            r_mem_out  <= r_mem[r_idx];
          end
          if (w_step) begin
            if (!w_last) begin
              r_idx <= w_idx_inc;
            end else if (r_fill_pend) begin
              r_state    <= S_FILLING;
              r_rdreq    <= 1'b1;
              r_idx      <= '0;
              r_rcv      <= '0;
              r_mem_addr <= {r_new_tag, {LSBBITS{1'b0}}};
            end else begin
              r_state <= S_CACHING;
              r_empty <= 1'b1;
              r_ttl   <= '0;
            end
          end
        end
        (r_state == S_FILLING): begin
          if (r_rdreq && mem_ready) begin
            if (w_last) begin
              r_rdreq <= 1'b0;
            end else begin
              r_idx      <= w_idx_inc;
              r_mem_addr <= {r_new_tag, w_idx_inc, {OFFB{1'b0}}};
            end
          end
          if (mem_in_valid) begin
            r_rcv <= r_rcv + 1'b1;
            if (&r_rcv) begin
              r_state     <= S_CACHING;
              r_tag       <= r_new_tag;
              r_empty     <= 1'b0;
              r_dirty     <= '0;
              r_ttl       <= TTLMAX;
              r_fill_pend <= 1'b0;
            end
          end
        end
        default: r_state <= S_CACHING;
      endcase
    end
  end

endmodule
